cmp_cubic_acc: RTL and testbench

CMP_CUBIC_ACC -- requirements
Module: cmp_cubic_acc

---
 rtl/cmp_cubic_acc.sv | 163 ++++++++++++++++
 tb/tb_cmp_cubic_acc.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_cubic_acc.sv
// Tiled outer-product accumulator: each beat reduces DEPTH layers into a SIZE x SIZE tile, summed over cfg_tiles beats.
// Define CMP_SATURATE_EN to clamp overflowing accumulates instead of wrapping (ovf is raised either way).
module cmp_cubic_acc #(
    parameter int DATA_WID = 16,
    parameter int SIZE     = 8,
    parameter int DEPTH    = 8,
    parameter int ACC_WID  = 48
) (
    input  logic                            clock,
    input  logic                            rst,
    input  logic                            start,
    input  logic [15:0]                     cfg_tiles,
    input  logic [DEPTH*SIZE*DATA_WID-1:0]  weights,
    input  logic [DEPTH*SIZE*DATA_WID-1:0]  pixels,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [SIZE*SIZE*ACC_WID-1:0]    acc_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            ovf
);
    localparam int SUM_W = 2*DATA_WID + $clog2(DEPTH);
    localparam int NEL   = SIZE*SIZE;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [15:0] tiles;
    logic [15:0] beat_cnt;
    logic        job_start;
    logic        accept;
    logic        last_beat;
    logic        step_ovf;

    logic                       vld_p1;
    logic signed [SUM_W-1:0]    sum_p0  [NEL];
    logic signed [SUM_W-1:0]    sum_p1  [NEL];
    logic signed [ACC_WID-1:0]  acc_p2  [NEL];
    logic signed [ACC_WID-1:0]  acc_nxt [NEL];

    function automatic logic signed [2*DATA_WID-1:0] mul(
        input logic signed [DATA_WID-1:0] a,
        input logic signed [DATA_WID-1:0] b
    );
        return (2*DATA_WID)'(a) * (2*DATA_WID)'(b);
    endfunction

    // Signed overflow: operands agree in sign but the wrapped sum does not.
    function automatic logic add_ovf(
        input logic signed [ACC_WID-1:0] a,
        input logic signed [ACC_WID-1:0] b
    );
        logic signed [ACC_WID-1:0] s;
        s = a + b;
        return (a[ACC_WID-1] == b[ACC_WID-1]) && (s[ACC_WID-1] != a[ACC_WID-1]);
    endfunction

    function automatic logic signed [ACC_WID-1:0] acc_add(
        input logic signed [ACC_WID-1:0] a,
        input logic signed [ACC_WID-1:0] b
    );
        logic signed [ACC_WID-1:0] s;
        s = a + b;
`ifdef CMP_SATURATE_EN
        if (add_ovf(a, b))
            s = a[ACC_WID-1] ? {1'b1, {(ACC_WID-1){1'b0}}} : {1'b0, {(ACC_WID-1){1'b1}}};
`endif
        return s;
    endfunction

    assign job_start = (state == IDLE) && start && (cfg_tiles != 16'd0);
    assign in_ready  = (state == ACC) && (beat_cnt < tiles);
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (beat_cnt == tiles - 16'd1);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clock or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (job_start) state_next = ACC;
            ACC:     if (last_beat) state_next = DRAIN;
            DRAIN:   if (vld_p1)    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            tiles    <= '0;
            beat_cnt <= '0;
        end else if (job_start) begin
            tiles    <= cfg_tiles;
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 16'd1;
        end
    end

    // Stage 0: full-precision beat sum, element (j,k) at j*SIZE+k.
    always_comb begin
        for (int j = 0; j < SIZE; j++) begin
            for (int k = 0; k < SIZE; k++) begin
                sum_p0[j*SIZE+k] = '0;
                for (int d = 0; d < DEPTH; d++) begin
                    sum_p0[j*SIZE+k] = sum_p0[j*SIZE+k] + SUM_W'(mul(
                        $signed(weights[(d*SIZE+j)*DATA_WID +: DATA_WID]),
                        $signed(pixels[(d*SIZE+k)*DATA_WID +: DATA_WID])));
                end
            end
        end
    end

    // Stage 1: register the accepted beat's sums.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            for (int i = 0; i < NEL; i++) sum_p1[i] <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                for (int i = 0; i < NEL; i++) sum_p1[i] <= sum_p0[i];
            end
        end
    end

    always_comb begin
        step_ovf = 1'b0;
        for (int i = 0; i < NEL; i++) begin
            acc_nxt[i] = acc_add(acc_p2[i], ACC_WID'(sum_p1[i]));
            step_ovf   = step_ovf | add_ovf(acc_p2[i], ACC_WID'(sum_p1[i]));
        end
    end

    // Stage 2: accumulate; cleared only by a new job so the last result persists in IDLE.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            for (int i = 0; i < NEL; i++) acc_p2[i] <= '0;
        end else if (job_start) begin
            ovf <= 1'b0;
            for (int i = 0; i < NEL; i++) acc_p2[i] <= '0;
        end else if (vld_p1) begin
            ovf <= ovf | step_ovf;
            for (int i = 0; i < NEL; i++) acc_p2[i] <= acc_nxt[i];
        end
    end

    for (genvar g = 0; g < NEL; g++) begin : g_out
        assign acc_out[g*ACC_WID +: ACC_WID] = acc_p2[g];
    end

endmodule

// File: tb/tb_cmp_cubic_acc.sv
// Self-checking bench for cmp_cubic_acc (SIZE=2, DEPTH=2, DATA_WID=16, ACC_WID=33) against a job-level reference model.
module tb_cmp_cubic_acc;
    localparam int DW  = 16;
    localparam int SZ  = 2;
    localparam int DP  = 2;
    localparam int AW  = 33;
    localparam int NEL = SZ*SZ;
    localparam longint MAXV = (longint'(1) <<< (AW-1)) - 1;
    localparam longint MINV = -MAXV - 1;

    logic                   clock = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [15:0]            cfg_tiles = '0;
    logic [DP*SZ*DW-1:0]    weights = '0;
    logic [DP*SZ*DW-1:0]    pixels = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [NEL*AW-1:0]      acc_out;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic                   busy;
    logic                   ovf;

    cmp_cubic_acc #(.DATA_WID(DW), .SIZE(SZ), .DEPTH(DP), .ACC_WID(AW)) dut (
        .clock(clock), .rst(rst), .start(start), .cfg_tiles(cfg_tiles),
        .weights(weights), .pixels(pixels), .in_valid(in_valid), .in_ready(in_ready),
        .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .ovf(ovf)
    );

    always #5 clock = ~clock;

    int     wv [DP*SZ];
    int     pv [DP*SZ];

    // Reference model: job status, beats taken, exact sums, and the edge of the last acceptance.
    bit     m_job;
    int     m_tiles;
    int     m_beats;
    longint m_cyc = 0;
    longint m_acc_edge;
    longint m_true [NEL];
    longint m_sat  [NEL];
    bit     m_ovf;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_bit(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic longint wrap_acc(longint v);
        logic [AW-1:0] t;
        t = v[AW-1:0];
        return longint'($signed(t));
    endfunction

    function automatic longint exp_elem(int i);
`ifdef CMP_SATURATE_EN
        return m_sat[i];
`else
        return wrap_acc(m_true[i]);
`endif
    endfunction

    function automatic longint dut_elem(int i);
        logic [AW-1:0] t;
        t = acc_out[i*AW +: AW];
        return longint'($signed(t));
    endfunction

    function automatic bit exp_ready();
        return m_job && (m_beats < m_tiles);
    endfunction

    // Result is presented two cycles after the last beat is taken.
    function automatic bit exp_ov();
        return m_job && (m_beats == m_tiles) && (m_cyc >= m_acc_edge + 1);
    endfunction

    task automatic model_reset();
        m_job = 1'b0;
        m_tiles = 0;
        m_beats = 0;
        m_acc_edge = 0;
        m_ovf = 1'b0;
        for (int i = 0; i < NEL; i++) begin
            m_true[i] = 0;
            m_sat[i] = 0;
        end
    endtask

    task automatic add_beat();
        longint s;
        longint v;
        for (int j = 0; j < SZ; j++) begin
            for (int k = 0; k < SZ; k++) begin
                s = 0;
                for (int d = 0; d < DP; d++)
                    s += longint'(wv[d*SZ+j]) * longint'(pv[d*SZ+k]);
                m_true[j*SZ+k] += s;
                if (m_true[j*SZ+k] > MAXV || m_true[j*SZ+k] < MINV) m_ovf = 1'b1;
                v = m_sat[j*SZ+k] + s;
                if (v > MAXV) v = MAXV;
                if (v < MINV) v = MINV;
                m_sat[j*SZ+k] = v;
            end
        end
    endtask

    task automatic model_step();
        bit ov;
        if (rst) begin
            model_reset();
        end else begin
            ov = exp_ov();
            if (!m_job) begin
                if (start && cfg_tiles != 16'd0) begin
                    model_reset();
                    m_job = 1'b1;
                    m_tiles = int'(cfg_tiles);
                end
            end else begin
                if (in_valid && m_beats < m_tiles) begin
                    add_beat();
                    m_beats++;
                    if (m_beats == m_tiles) m_acc_edge = m_cyc + 1;
                end
                if (ov && out_ready) m_job = 1'b0;
            end
        end
        m_cyc++;
    endtask

    task automatic compare_all();
        if (rst) return;
        chk_bit("busy", busy, m_job);
        chk_bit("in_ready", in_ready, exp_ready());
        chk_bit("out_valid", out_valid, exp_ov());
        if (exp_ov()) begin
            chk_bit("ovf", ovf, m_ovf);
            for (int i = 0; i < NEL; i++) chk($sformatf("acc_out[%0d]", i), dut_elem(i), exp_elem(i));
        end else if (!m_job) begin
            for (int i = 0; i < NEL; i++) chk($sformatf("idle acc_out[%0d]", i), dut_elem(i), exp_elem(i));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic pack();
        for (int n = 0; n < DP*SZ; n++) begin
            weights[n*DW +: DW] = DW'(wv[n]);
            pixels[n*DW +: DW]  = DW'(pv[n]);
        end
    endtask

    task automatic set_const(int w, int p);
        for (int n = 0; n < DP*SZ; n++) begin
            wv[n] = w;
            pv[n] = p;
        end
        pack();
    endtask

    task automatic set_rand(int lim);
        for (int n = 0; n < DP*SZ; n++) begin
            wv[n] = int'($urandom_range(0, 2*lim)) - lim;
            pv[n] = int'($urandom_range(0, 2*lim)) - lim;
        end
        pack();
    endtask

    task automatic do_start(int tiles);
        start = 1'b1;
        cfg_tiles = 16'(tiles);
        tick();
        start = 1'b0;
    endtask

    task automatic feed(int gap_pct, int lim);
        int guard = 0;
        while (m_job && m_beats < m_tiles && guard < 5000) begin
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            if (lim > 0) set_rand(lim);
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL feed timeout: beats %0d of %0d", m_beats, m_tiles);
        end
    endtask

    task automatic finish_job(int hold);
        int guard = 0;
        while (!exp_ov() && guard < 50) begin
            tick();
            guard++;
        end
        if (!exp_ov()) begin
            n_checks++;
            n_fail++;
            $display("FAIL done timeout: out_valid %b, expected 1", out_valid);
        end
        for (int c = 0; c < hold; c++) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        chk_bit("reset busy", busy, 1'b0);
        chk_bit("reset in_ready", in_ready, 1'b0);
        chk_bit("reset out_valid", out_valid, 1'b0);
        chk_bit("reset ovf", ovf, 1'b0);
        for (int i = 0; i < NEL; i++) chk("reset acc_out", dut_elem(i), 0);
        rst = 1'b0;
        tick();

        // Weights 1, pixels 2, three back-to-back beats.
        set_const(1, 2);
        do_start(3);
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        chk_bit("t1 out_valid one cycle after last beat", out_valid, 1'b0);
        tick();
        chk_bit("t1 out_valid two cycles after last beat", out_valid, 1'b1);
        for (int i = 0; i < NEL; i++) chk("t1 acc_out", dut_elem(i), 12);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Negative single beat with back-pressure.
        set_const(-3, 5);
        do_start(1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk_bit("t2 out_valid held", out_valid, 1'b1);
            tick();
        end
        for (int i = 0; i < NEL; i++) chk("t2 acc_out", dut_elem(i), -30);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_bit("t2 out_valid after handshake", out_valid, 1'b0);

        // Zero-tile start ignored; start while busy and during handshake ignored.
        start = 1'b1;
        cfg_tiles = 16'd0;
        tick();
        start = 1'b0;
        chk_bit("t3 zero-tile busy", busy, 1'b0);
        set_const(2, 3);
        do_start(2);
        in_valid = 1'b1;
        tick();
        start = 1'b1;
        cfg_tiles = 16'd5;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        tick();
        chk_bit("t3 out_valid", out_valid, 1'b1);
        for (int i = 0; i < NEL; i++) chk("t3 acc_out", dut_elem(i), 24);
        out_ready = 1'b1;
        start = 1'b1;
        cfg_tiles = 16'd3;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        chk_bit("t3 start at handshake ignored", busy, 1'b0);

        // Overflow at ACC_WID=33.
        set_const(-32768, -32768);
        do_start(3);
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        chk_bit("t4 ovf", ovf, 1'b1);
`ifdef CMP_SATURATE_EN
        for (int i = 0; i < NEL; i++) chk("t4 acc_out saturated", dut_elem(i), 64'sd4294967295);
`else
        for (int i = 0; i < NEL; i++) chk("t4 acc_out wrapped", dut_elem(i), -64'sd2147483648);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset during the second of four beats.
        set_rand(500);
        do_start(4);
        in_valid = 1'b1;
        tick();
        set_rand(500);
        #2;
        rst = 1'b1;
        #1;
        chk_bit("t5 reset busy", busy, 1'b0);
        chk_bit("t5 reset in_ready", in_ready, 1'b0);
        chk_bit("t5 reset out_valid", out_valid, 1'b0);
        chk_bit("t5 reset ovf", ovf, 1'b0);
        for (int i = 0; i < NEL; i++) chk("t5 reset acc_out", dut_elem(i), 0);
        model_reset();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        do_start(4);
        feed(0, 500);
        finish_job(1);

        // Long job with random valid gaps, then short random jobs.
        do_start(100);
        feed(40, 1000);
        finish_job(2);
        for (int r = 0; r < 4; r++) begin
            do_start(int'($urandom_range(1, 12)));
            feed(30, 1000);
            finish_job(int'($urandom_range(0, 3)));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
